dmem_arbiter: RTL and testbench

Single-port arbiter and sequencer in front of the data memory. The data memory has a combinational read, a write on the clock edge, a 15-bit address and 16-bit words. Three clients share one access slot per cycle: the CPU data port, an internal screen-scan engine, and an internal keyboard-mirror writer. The screen-scan engine streams the screen region into a small FIFO for the display path. The keyboard-mirror writer copies kb_in into the keyboard word.

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: keyboard mirror, CPU port and screen-scan
// engine share one memory slot per cycle; scanned words stream out via a FIFO.
module dmem_arbiter #(
  parameter int ADDR_W       = 15,
  parameter int SCREEN_BASE  = 16384,
  parameter int SCREEN_WORDS = 8192,
  parameter int KBD_ADDR     = 24576,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic [DATA_W-1:0] kb_in,
  input  logic              scan_en,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_sof,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [ADDR_W-1:0] mem_adr,
  output logic              mem_load,
  output logic [DATA_W-1:0] mem_d_in,
  input  logic [DATA_W-1:0] mem_d_out
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] SCREEN_BASE_A = ADDR_W'(SCREEN_BASE);
  localparam logic [ADDR_W-1:0] KBD_A         = ADDR_W'(KBD_ADDR);
  localparam logic [ADDR_W-1:0] LAST_IDX      = ADDR_W'(SCREEN_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT      = CNT_W'(FIFO_DEPTH);

  typedef enum logic {RR_CPU, RR_SCAN} rr_t;

  rr_t               rr;
  logic [DATA_W-1:0] kb_q;
  logic              kbd_pend;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic req_k, req_c, req_s;
  logic gnt_k, gnt_c, gnt_s;
  logic pop;

  // Grant stage: requests, priority/round-robin and the memory bus drive
  always_comb begin
    req_k = kbd_pend;
    req_c = cpu_req & ~cpu_ack;
    req_s = scan_en & (count < FULL_CNT);
    gnt_k = rst_n & req_k;
    gnt_c = rst_n & ~req_k & req_c & (~req_s | (rr == RR_CPU));
    gnt_s = rst_n & ~req_k & req_s & (~req_c | (rr == RR_SCAN));

    mem_adr  = '0;
    mem_load = 1'b0;
    mem_d_in = '0;
    if (gnt_k) begin
      mem_adr  = KBD_A;
      mem_load = 1'b1;
      mem_d_in = kb_q;
    end else if (gnt_c) begin
      mem_adr  = cpu_adr;
      // The keyboard word belongs to the mirror; CPU writes there are dropped.
      mem_load = cpu_we & (cpu_adr != KBD_A);
      mem_d_in = cpu_wdata;
    end else if (gnt_s) begin
      mem_adr  = SCREEN_BASE_A + idx;
    end
  end

  always_comb begin
    pix_valid = (count != '0);
    pix_data  = '0;
    pix_sof   = 1'b0;
    if (pix_valid) begin
      pix_data = fifo_mem[rd_ptr][DATA_W-1:0];
      pix_sof  = fifo_mem[rd_ptr][DATA_W];
    end
    pop = pix_valid & pix_ready;
  end

  // Response stage: CPU completion, keyboard tracking, scan index and FIFO control
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      kb_q      <= '0;
      kbd_pend  <= 1'b0;
      rr        <= RR_CPU;
      idx       <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
    end else begin
      cpu_ack <= gnt_c;
      if (gnt_c)
        cpu_rdata <= mem_d_out;

      // A fresh key code always re-arms the write so only the newest value lands.
      if (kb_in != kb_q) begin
        kb_q     <= kb_in;
        kbd_pend <= 1'b1;
      end else if (gnt_k) begin
        kbd_pend <= 1'b0;
      end

      if (gnt_c)
        rr <= RR_SCAN;
      else if (gnt_s)
        rr <= RR_CPU;

      if (!scan_en) begin
        idx    <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (gnt_s) begin
          idx    <= (idx == LAST_IDX) ? '0 : idx + ADDR_W'(1);
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_W'(1);
        case ({gnt_s, pop})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // FIFO storage is pure data; validity is carried by count alone.
  always_ff @(posedge clk) begin
    if (gnt_s)
      fifo_mem[wr_ptr] <= {(idx == '0), mem_d_out};
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: behavioural data memory, CPU read-data and
// pixel-stream expectation queues, plus directed bus-level checks.
module tb_dmem_arbiter;
  localparam int ADDR_W = 15;
  localparam int SW     = 8;
  localparam int SB     = 16384;
  localparam int KA     = 24576;

  logic              clk;
  logic              rst_n;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_adr;
  logic [15:0]       cpu_wdata;
  logic [15:0]       cpu_rdata;
  logic              cpu_ack;
  logic [15:0]       kb_in;
  logic              scan_en;
  logic [15:0]       pix_data;
  logic              pix_sof;
  logic              pix_valid;
  logic              pix_ready;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_load;
  logic [15:0]       mem_d_in;
  logic [15:0]       mem_d_out;

  dmem_arbiter #(.SCREEN_WORDS(SW)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .kb_in(kb_in), .scan_en(scan_en),
    .pix_data(pix_data), .pix_sof(pix_sof), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .mem_adr(mem_adr), .mem_load(mem_load),
    .mem_d_in(mem_d_in), .mem_d_out(mem_d_out)
  );

  logic [15:0] mem [0:32767];
  assign mem_d_out = mem[mem_adr];
  always @(posedge clk) if (mem_load) mem[mem_adr] <= mem_d_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [15:0] cpu_q[$];
  logic [16:0] pix_q[$];

  function automatic logic [15:0] init_val(input logic [ADDR_W-1:0] a);
    return {1'b0, a} ^ 16'hA5A5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one CPU access; reports edges to ack and the bus seen in the first cycle.
  task automatic cpu_go(input logic we, input logic [ADDR_W-1:0] adr, input logic [15:0] wd,
                        input logic [15:0] exp, output int lat, output logic [ADDR_W-1:0] a0,
                        output logic l0, output logic [15:0] d0);
    logic done;
    cpu_q.push_back(exp);
    cpu_req = 1'b1; cpu_we = we; cpu_adr = adr; cpu_wdata = wd;
    #1;
    a0 = mem_adr; l0 = mem_load; d0 = mem_d_in;
    lat = 0; done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      step();
      lat++;
      if (cpu_ack === 1'b1) done = 1'b1;
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    check("cpu_ack_seen", 32'(done), 32'd1);
    step();
  endtask

  always @(negedge clk) begin
    if (cpu_ack === 1'b1) begin
      check("cpu_ack_expected", 32'(cpu_q.size() != 0), 32'd1);
      if (cpu_q.size() != 0) check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_q.pop_front()));
    end
    if (scan_en && pix_ready && pix_valid === 1'b1) begin
      check("pix_expected", 32'(pix_q.size() != 0), 32'd1);
      if (pix_q.size() != 0) check("pix_word", 32'({pix_sof, pix_data}), 32'(pix_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    logic done;
    logic [ADDR_W-1:0] a0;
    logic l0;
    logic [15:0] d0;
    int tab [12];

    for (int i = 0; i < 32768; i++) mem[i] = init_val(ADDR_W'(i));

    // Reset with a CPU request already pending
    rst_n = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 15'd200; cpu_wdata = '0;
    kb_in = '0; scan_en = 1'b0; pix_ready = 1'b0;
    repeat (3) begin
      step(); #1;
      check("rst_ack", 32'(cpu_ack), 32'd0);
      check("rst_load", 32'(mem_load), 32'd0);
      check("rst_pix_valid", 32'(pix_valid), 32'd0);
      check("rst_adr", 32'(mem_adr), 32'd0);
    end
    cpu_q.push_back(init_val(15'd200));
    rst_n = 1'b1;
    #1;
    check("post_rst_grant_adr", 32'(mem_adr), 32'd200);
    lat = 0; done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step(); lat++;
      if (cpu_ack === 1'b1) done = 1'b1;
    end
    check("rst_ack_lat", 32'(lat), 32'd1);
    cpu_req = 1'b0;
    step();

    // CPU only: write then read back
    cpu_go(1'b1, 15'd100, 16'h1234, init_val(15'd100), lat, a0, l0, d0);
    check("wr_adr", 32'(a0), 32'd100);
    check("wr_load", 32'(l0), 32'd1);
    check("wr_din", 32'(d0), 32'h1234);
    check("wr_lat", 32'(lat), 32'd1);
    cpu_go(1'b0, 15'd100, 16'h0, 16'h1234, lat, a0, l0, d0);
    check("rd_load", 32'(l0), 32'd0);
    check("rd_lat", 32'(lat), 32'd1);

    // Contention: CPU held, scan enabled, display stalled
    tab = '{16384, 300, 16385, 300, 16386, 300, 16387, 300, 0, 300, 0, 300};
    for (int i = 0; i < 6; i++) cpu_q.push_back(init_val(15'd300));
    scan_en = 1'b1; pix_ready = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 15'd300;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) step();
      #1;
      check("cont_adr", 32'(mem_adr), 32'(tab[k]));
      if (k >= 8) check("cont_pix_valid", 32'(pix_valid), 32'd1);
    end
    step();
    cpu_req = 1'b0;
    step();
    check("cont_acks_drained", 32'(cpu_q.size()), 32'd0);
    scan_en = 1'b0;
    step(); #1;
    check("flush_pix_valid", 32'(pix_valid), 32'd0);

    // Scan wrap with a free-running display
    for (int i = 0; i < 16; i++)
      pix_q.push_back({(i % SW) == 0, init_val(ADDR_W'(SB + (i % SW)))});
    scan_en = 1'b1; pix_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) step();
      #1;
      check("wrap_adr", 32'(mem_adr), 32'(SB + (k % SW)));
      if (k == 1) check("wrap_sof0", 32'(pix_sof), 32'd1);
      if (k == 2) check("wrap_sof1", 32'(pix_sof), 32'd0);
    end
    step(); #1;
    check("wrap_sof8", 32'(pix_sof), 32'd1);
    @(negedge clk); #1;
    check("wrap_consumed", 32'(pix_q.size()), 32'd7);
    scan_en = 1'b0; pix_ready = 1'b0;
    pix_q.delete();
    step();

    // Keyboard change delays a CPU access by one slot
    kb_in = 16'h0041;
    step();
    cpu_go(1'b0, 15'd500, 16'h0, init_val(15'd500), lat, a0, l0, d0);
    check("kb_adr", 32'(a0), 32'(KA));
    check("kb_load", 32'(l0), 32'd1);
    check("kb_din", 32'(d0), 32'h41);
    check("kb_cpu_lat", 32'(lat), 32'd2);
    check("kb_mem", 32'(mem[KA]), 32'h41);
    cpu_go(1'b1, 15'(KA), 16'h0099, 16'h0041, lat, a0, l0, d0);
    check("kbw_load", 32'(l0), 32'd0);
    check("kbw_lat", 32'(lat), 32'd1);
    check("kbw_mem", 32'(mem[KA]), 32'h41);

    // Back-to-back key changes: the newest value is the one left in memory
    kb_in = 16'h0010; step();
    kb_in = 16'h0020; step();
    kb_in = 16'h0030; step(); #1;
    check("kb_last_load", 32'(mem_load), 32'd1);
    check("kb_last_din", 32'(mem_d_in), 32'h30);
    step(); #1;
    check("kb_idle_load", 32'(mem_load), 32'd0);
    check("kb_final_mem", 32'(mem[KA]), 32'h30);

    // Scan dropped mid-frame restarts at frame start
    scan_en = 1'b1; pix_ready = 1'b0;
    repeat (3) step();
    scan_en = 1'b0;
    step(); #1;
    check("drop_pix_valid", 32'(pix_valid), 32'd0);
    check("drop_pix_data", 32'(pix_data), 32'd0);
    check("drop_pix_sof", 32'(pix_sof), 32'd0);
    for (int i = 0; i < 4; i++)
      pix_q.push_back({i == 0, init_val(ADDR_W'(SB + i))});
    scan_en = 1'b1; pix_ready = 1'b1;
    #1;
    check("restart_adr", 32'(mem_adr), 32'(SB));
    step(); #1;
    check("restart_sof", 32'(pix_sof), 32'd1);
    repeat (3) step();
    @(negedge clk); #1;
    check("restart_consumed", 32'(pix_q.size()), 32'd0);
    scan_en = 1'b0; pix_ready = 1'b0;
    step();

    // Reset applied mid-operation
    scan_en = 1'b1; kb_in = 16'h0055;
    step(); step();
    rst_n = 1'b0;
    #1;
    check("midrst_load", 32'(mem_load), 32'd0);
    check("midrst_adr", 32'(mem_adr), 32'd0);
    step(); #1;
    check("midrst_pix_valid", 32'(pix_valid), 32'd0);
    check("midrst_ack", 32'(cpu_ack), 32'd0);
    check("midrst_pix_sof", 32'(pix_sof), 32'd0);
    check("cpu_q_drained", 32'(cpu_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
